stream_demux_1_4: RTL



---
 rtl/stream_demux_1_4_if.sv | 39 +++
 rtl/stream_demux_1_4.sv | 72 +++++++
 2 files changed

// File: rtl/stream_demux_1_4_if.sv
// stream_demux_1_4 bus bundle
// one input stream in, four channel streams out
interface stream_demux_1_4_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;

  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         full;

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  full
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output full
  );

endinterface

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: 1-to-4 stream router
// with a private FIFO per output channel
module stream_demux_1_4 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  stream_demux_1_4_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [3:0]         vld;
  logic [3:0]         fl;
  logic [4*WIDTH-1:0] dat;
  logic               rdy;

  // a full channel still takes a word when it pops this cycle
  assign rdy = !fl[bus.in_sel]
            || bus.out_ready[bus.in_sel];

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.full      = fl;
  assign bus.out_data  = dat;

  for (genvar i = 0; i < 4; i++) begin : g_ch

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign push = bus.in_valid && rdy
               && (bus.in_sel == 2'(i));
    assign pop  = (cnt != '0) && bus.out_ready[i];

    assign vld[i] = (cnt != '0);
    assign fl[i]  = (cnt == FULLC);
    assign dat[i*WIDTH +: WIDTH] = mem[rd];

    // pointers, count and storage of this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd  <= '0;
        wr  <= '0;
        cnt <= '0;
        for (int k = 0; k < DEPTH; k++)
          mem[k] <= '0;
      end else begin
        if (push) begin
          mem[wr] <= bus.in_data;
          wr      <= wr + AW'(1);
        end
        if (pop)
          rd <= rd + AW'(1);
        unique case (1'b1)
          push && !pop: cnt <= cnt + CW'(1);
          pop && !push: cnt <= cnt - CW'(1);
          default:      cnt <= cnt;
        endcase
      end
    end

  end

endmodule
